// File: rtl/mem_stage.sv
// MIPS32 memory-access stage: byte/half/word loads and stores against an internal
// data memory with programmable wait states, registering results into MEM/WB.
module mem_stage #(
    parameter int SIZE        = 32,
    parameter int ADDR_SIZE   = 5,
    parameter int S_WB        = 2,
    parameter int S_M         = 3,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [S_WB-1:0]      WB,
    input  logic [S_M-1:0]       M,
    input  logic                 zero_in,
    input  logic [1:0]           mem_size,
    input  logic                 mem_unsigned,
    input  logic [SIZE-1:0]      alu_result,
    input  logic [SIZE-1:0]      store_data,
    input  logic [ADDR_SIZE-1:0] AWriteReg_in,
    output logic                 pcsrc,
    output logic                 stall,
    output logic                 misalign,
    output logic [S_WB-1:0]      WB_out,
    output logic [SIZE-1:0]      read_data,
    output logic [SIZE-1:0]      alu_out,
    output logic [ADDR_SIZE-1:0] AWriteReg
);

    localparam int         AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [31:0]   mem_q [DEPTH];
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          req, is_store, is_load, aligned, go, done;
    logic [SIZE-1:0] load_d;
    logic          unused_addr_bits;

    assign idx              = alu_result[AW+1:2];
    assign lane             = alu_result[1:0];
    assign unused_addr_bits = ^alu_result[SIZE-1:AW+2];

    // Read+write both set means the access is a store only.
    assign req      = M[1] | M[0];
    assign is_store = M[0];
    assign is_load  = M[1] & ~M[0];

    always_comb begin
        aligned = 1'b0;
        case (mem_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~lane[0];
            2'b10:   aligned = (lane == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign go    = req & aligned;
    assign stall = go & (cnt_q != WS);
    assign done  = go & (cnt_q == WS);
    assign pcsrc = M[2] & zero_in;
    assign cnt_d = stall ? cnt_q + 4'd1 : 4'd0;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  ln);
        logic [31:0] r;
        r = old_w;
        case (sz)
            2'b00:   r[{ln, 3'b000} +: 8]       = wdata[7:0];
            2'b01:   r[{ln[1], 4'b0000} +: 16]  = wdata[15:0];
            default: r                          = wdata;
        endcase
        return r;
    endfunction

    function automatic logic [SIZE-1:0] extract_ext(input logic [31:0] w,
                                                    input logic [1:0]  sz,
                                                    input logic [1:0]  ln,
                                                    input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [SIZE-1:0] r;
        b = w[{ln, 3'b000} +: 8];
        h = w[{ln[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   r = uns ? SIZE'(b) : SIZE'($signed(b));
            2'b01:   r = uns ? SIZE'(h) : SIZE'($signed(h));
            default: r = SIZE'(w);
        endcase
        return r;
    endfunction

    assign load_d = (done && is_load) ?
                    extract_ext(mem_q[idx], mem_size, lane, mem_unsigned) : '0;

    // Gated by rst_n so a store caught by reset on its completion edge is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && done && is_store)
            mem_q[idx] <= merge_lanes(mem_q[idx], store_data[31:0], mem_size, lane);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            WB_out    <= '0;
            read_data <= '0;
            alu_out   <= '0;
            AWriteReg <= '0;
            misalign  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            alu_out   <= alu_result;
            AWriteReg <= AWriteReg_in;
            read_data <= load_d;
            misalign  <= req & ~aligned;
            WB_out    <= (stall || (req && !aligned)) ? '0 : WB;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: wait-state stalls, lane select/extension,
// misalignment, passthrough, branch select, reset abort and address wrap.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  WB;
    logic [2:0]  M;
    logic        zero_in;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  AWriteReg_in;
    logic        pcsrc, stall, misalign;
    logic [1:0]  WB_out;
    logic [31:0] read_data, alu_out;
    logic [4:0]  AWriteReg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage #(.SIZE(32), .ADDR_SIZE(5), .S_WB(2), .S_M(3), .DEPTH(256), .WAIT_STATES(2)) dut (
        .clk(clk), .rst_n(rst_n), .WB(WB), .M(M), .zero_in(zero_in),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .alu_result(alu_result),
        .store_data(store_data), .AWriteReg_in(AWriteReg_in), .pcsrc(pcsrc),
        .stall(stall), .misalign(misalign), .WB_out(WB_out), .read_data(read_data),
        .alu_out(alu_out), .AWriteReg(AWriteReg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one EX/MEM op at a negedge, ride out its stall window checking for
    // bubbles, and return after the completion edge (+1) with stall count.
    task automatic run_op(input logic [1:0] wb, input logic [2:0] m, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, output int n_stall);
        @(negedge clk);
        WB = wb; M = m; mem_size = sz; mem_unsigned = uns;
        alu_result = addr; store_data = data; AWriteReg_in = rd;
        n_stall = 0;
        #1;
        while (stall && n_stall < 20) begin
            @(posedge clk); #1;
            chk("wb_bubble", 32'(WB_out), 32'h0);
            n_stall++;
        end
        if (n_stall >= 20) chk("stall_timeout", 32'(n_stall), 32'd2);
        @(posedge clk); #1;
    endtask

    int ns;

    initial begin
        rst_n = 1'b0; WB = '0; M = '0; zero_in = 1'b0; mem_size = '0; mem_unsigned = 1'b0;
        alu_result = '0; store_data = '0; AWriteReg_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb", 32'(WB_out), 0);
        chk("rst_rd", read_data, 0);
        chk("rst_alu", alu_out, 0);
        chk("rst_awr", 32'(AWriteReg), 0);
        chk("rst_mis", 32'(misalign), 0);
        chk("rst_stall", 32'(stall), 0);
        @(negedge clk) rst_n = 1'b1;

        // Word store then word load, two wait states each
        run_op(2'b11, 3'b001, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd3, ns);
        chk("sw_stalls", ns, 2);
        chk("sw_wb", 32'(WB_out), 32'h3);
        chk("sw_rd", read_data, 0);
        chk("sw_alu", alu_out, 32'h10);
        run_op(2'b01, 3'b010, 2'b10, 1'b0, 32'h10, 32'h0, 5'd4, ns);
        chk("lw_stalls", ns, 2);
        chk("lw_rd", read_data, 32'hDEADBEEF);
        chk("lw_wb", 32'(WB_out), 32'h1);
        chk("lw_awr", 32'(AWriteReg), 32'd4);

        // Byte store and sign/zero-extended lane loads
        run_op(2'b11, 3'b001, 2'b00, 1'b0, 32'h13, 32'h12345680, 5'd0, ns);
        chk("sb_stalls", ns, 2);
        run_op(2'b01, 3'b010, 2'b00, 1'b0, 32'h13, 32'h0, 5'd5, ns);
        chk("lb_s", read_data, 32'hFFFFFF80);
        run_op(2'b01, 3'b010, 2'b00, 1'b1, 32'h13, 32'h0, 5'd5, ns);
        chk("lbu", read_data, 32'h00000080);
        run_op(2'b01, 3'b010, 2'b10, 1'b0, 32'h10, 32'h0, 5'd5, ns);
        chk("lw_after_sb", read_data, 32'h80ADBEEF);
        run_op(2'b01, 3'b010, 2'b01, 1'b0, 32'h12, 32'h0, 5'd5, ns);
        chk("lh_s", read_data, 32'hFFFF80AD);
        run_op(2'b01, 3'b010, 2'b01, 1'b1, 32'h10, 32'h0, 5'd5, ns);
        chk("lhu", read_data, 32'h0000BEEF);
        run_op(2'b01, 3'b010, 2'b00, 1'b0, 32'h11, 32'h0, 5'd5, ns);
        chk("lb_s_lane1", read_data, 32'hFFFFFFBE);

        // Misaligned accesses
        run_op(2'b01, 3'b010, 2'b01, 1'b0, 32'h11, 32'h0, 5'd6, ns);
        chk("lh_mis_stalls", ns, 0);
        chk("lh_mis", 32'(misalign), 1);
        chk("lh_mis_wb", 32'(WB_out), 0);
        chk("lh_mis_awr", 32'(AWriteReg), 32'd6);
        run_op(2'b11, 3'b001, 2'b10, 1'b0, 32'h12, 32'h11111111, 5'd0, ns);
        chk("sw_mis_stalls", ns, 0);
        chk("sw_mis", 32'(misalign), 1);
        run_op(2'b01, 3'b010, 2'b11, 1'b0, 32'h10, 32'h0, 5'd0, ns);
        chk("rsvd_mis", 32'(misalign), 1);
        run_op(2'b01, 3'b010, 2'b10, 1'b0, 32'h10, 32'h0, 5'd5, ns);
        chk("mem_unchanged", read_data, 32'h80ADBEEF);
        chk("mis_cleared", 32'(misalign), 0);

        // R-type passthrough and branch select
        run_op(2'b10, 3'b000, 2'b10, 1'b0, 32'h1234, 32'h0, 5'd7, ns);
        chk("rt_stalls", ns, 0);
        chk("rt_wb", 32'(WB_out), 32'h2);
        chk("rt_alu", alu_out, 32'h1234);
        chk("rt_awr", 32'(AWriteReg), 32'd7);
        chk("rt_rd", read_data, 0);
        @(negedge clk); M = 3'b100; zero_in = 1'b1; #1;
        chk("pcsrc_taken", 32'(pcsrc), 1);
        chk("br_stall", 32'(stall), 0);
        zero_in = 1'b0; #1;
        chk("pcsrc_not", 32'(pcsrc), 0);
        M = 3'b000;

        // Half store merges into an existing word
        run_op(2'b11, 3'b001, 2'b10, 1'b0, 32'h20, 32'h01020304, 5'd0, ns);
        run_op(2'b11, 3'b001, 2'b01, 1'b0, 32'h22, 32'hFFFF5A5A, 5'd0, ns);
        run_op(2'b01, 3'b010, 2'b10, 1'b0, 32'h20, 32'h0, 5'd8, ns);
        chk("sh_merge", read_data, 32'h5A5A0304);

        // Reset in the middle of a store aborts it
        @(negedge clk);
        WB = 2'b11; M = 3'b001; mem_size = 2'b10; alu_result = 32'h20;
        store_data = 32'hAAAA5555; AWriteReg_in = 5'd9;
        @(posedge clk); #1;
        chk("abort_stall_cnt1", 32'(stall), 1);
        rst_n = 1'b0; #1;
        chk("abort_alu", alu_out, 0);
        chk("abort_awr", 32'(AWriteReg), 0);
        chk("abort_rd", read_data, 0);
        @(negedge clk); M = 3'b000; WB = 2'b00;
        @(negedge clk); rst_n = 1'b1; #1;
        chk("abort_stall_rel", 32'(stall), 0);
        @(posedge clk); #1;
        chk("abort_stall_rel2", 32'(stall), 0);
        run_op(2'b01, 3'b010, 2'b10, 1'b0, 32'h20, 32'h0, 5'd8, ns);
        chk("abort_kept", read_data, 32'h5A5A0304);

        // Address wrap: 0x400 aliases word 0
        run_op(2'b11, 3'b001, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, 5'd0, ns);
        run_op(2'b01, 3'b010, 2'b10, 1'b0, 32'h000, 32'h0, 5'd1, ns);
        chk("wrap", read_data, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS32 pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes that register's outputs (WB, M, zero, ALU result, store data, write-register address).
- It performs data-memory loads and stores: byte, half and word sizes, sign- or zero-extended, through an internal data memory that has a programmable number of wait states.
- It raises a stall while an access is in progress and registers its results into the MEM/WB outputs.
- It also produces the branch-taken select (PCSrc).

Parameters:
- SIZE, 32, datapath width.
- ADDR_SIZE, 5, register-file address width.
- S_WB, 2, width of the WB control bundle.
- S_M, 3, width of the M control bundle.
- DEPTH, 256, data-memory depth in 32-bit words (power of two).
- WAIT_STATES, 2, extra cycles per memory access (0..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- WB  in  S_WB  writeback control from EX/MEM.
- M  in  S_M  memory control from EX/MEM: [2]=Branch, [1]=MemRead, [0]=MemWrite.
- zero_in  in  1  ALU zero flag.
- mem_size  in  2  access size: 00=byte, 01=half, 10=word, 11=reserved (treated as misaligned).
- mem_unsigned  in  1  1=zero-extend loads, 0=sign-extend loads.
- alu_result  in  SIZE  byte address for loads/stores; also the passthrough result.
- store_data  in  SIZE  rt value to store.
- AWriteReg_in  in  ADDR_SIZE  destination register.
- pcsrc  out  1  Branch & zero_in, combinational.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; combinational.
- misalign  out  1  registered one-cycle pulse on a rejected access.
- WB_out  out  S_WB  MEM/WB writeback control.
- read_data  out  SIZE  extended load result.
- alu_out  out  SIZE  registered alu_result.
- AWriteReg  out  ADDR_SIZE  registered destination register.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - WB_out, read_data, alu_out, AWriteReg, misalign, and the wait counter clear to 0.
  - Memory contents are not reset.
  - Reset during an access aborts it: a pending store is NOT written, and no stall is asserted after release.
- Request and alignment:
  - req = M[1] | M[0].
  - Word accesses need addr[1:0]=00; half accesses need addr[0]=0; byte accesses have no constraint.
  - mem_size=11 is always misaligned.
  - If M[1] and M[0] are both 1, the access is treated as a store only.
- Misaligned request:
  - No stall and no memory write.
  - Next edge: misalign=1, WB_out=0 (bubble), alu_out/AWriteReg loaded as normal.
- Wait-state counter cnt (4 bits):
  - stall = req & aligned & (cnt != WAIT_STATES).
  - While stall=1: cnt increments each edge and WB_out is loaded with 0, so the stage emits bubbles and no duplicate writeback occurs. EX/MEM contents are held upstream.
  - Completion edge (cnt == WAIT_STATES): the store executes, the load data is captured, MEM/WB loads WB, alu_out and AWriteReg, and cnt returns to 0.
  - Total access latency is WAIT_STATES+1 cycles. With WAIT_STATES=0 there is no stall and the stage behaves as a plain register.
- Non-memory instructions (req=0): MEM/WB loads every edge with 1-cycle latency; read_data loads 0.
- Stores (little-endian, word index = addr[log2(DEPTH)+1:2], upper address bits ignored, so addresses wrap):
  - Byte: writes store_data[7:0] into lane addr[1:0].
  - Half: writes store_data[15:0] into lanes {addr[1],0}..+1.
  - Word: writes the full word.
  - Other lanes are unchanged. read_data after a store is 0.
- Loads: select the lane the same way, then extend to SIZE according to mem_unsigned.
- Back-to-back accesses: cnt is 0 on the cycle after completion, so the next access starts its own WAIT_STATES stall immediately.

Test Plan:
- WAIT_STATES=2; store word 0xDEADBEEF @0x10, then load word @0x10 -> stall high 2 cycles per access, each completes on the 3rd cycle; read_data=0xDEADBEEF; WB_out=0 during both stall windows.
- Store byte 0x80 @0x13, then load byte signed @0x13 -> read_data=0xFFFFFF80; load byte unsigned -> 0x00000080; word @0x10 reads 0x80ADBEEF.
- Load half @0x11 -> no stall, misalign pulses 1 cycle, WB_out=0, memory unchanged; word store @0x12 -> same, memory unchanged.
- R-type passthrough (M=000, WB=10, alu_result=0x1234, AWriteReg_in=7) -> next edge WB_out=10, alu_out=0x1234, AWriteReg=7, stall never asserted. Separately: M=100 with zero=1 -> pcsrc=1 in the same cycle.
- Store word 0xAAAA5555 @0x20 and assert rst_n=0 at cnt=1 -> outputs clear immediately, stall=0 after release, word @0x20 keeps its prior value.
- Address wrap, DEPTH=256: store @0x400 then load @0x000 -> same word returned.
